// File: rtl/dvs_ravens_pkg.sv
// rtl/dvs_ravens_pkg.sv - shared types and constants for the DVS-to-Ravens event path
//
// Purpose: default widths for DVS address-event capture, the {ts, addr} event
// record and the capture FSM state encoding.
package dvs_ravens_pkg;

  localparam int AER_ADDR_W     = 16;
  localparam int TS_W           = 16;
  localparam int EVT_FIFO_DEPTH = 8;

  // One captured camera event: timestamp in the upper bits, AER address below.
  typedef struct packed {
    logic [TS_W-1:0]       ts;
    logic [AER_ADDR_W-1:0] addr;
  } dvs_evt_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACK_HI = 2'd1,
    STALL  = 2'd2
  } aer_cap_state_t;

endpackage

// File: rtl/dvs_ravens_aer_capture_if.sv
// rtl/dvs_ravens_aer_capture_if.sv - camera AER handshake plus arbiter req/grant bundle
//
// Purpose: groups the camera-side 4-phase handshake and the arbiter-side
// request/grant/data signals of one capture stage.
// Signals: aer_req, aer_addr (camera -> stage), aer_ack (stage -> camera),
//          req, evt_data (stage -> arbiter), grant (arbiter -> stage).
// Modports: master = the capture stage, slave = camera/arbiter side.
interface dvs_ravens_aer_capture_if #(
  parameter int ADDR_W = 16,
  parameter int TS_W   = 16
);

  logic                     aer_req;
  logic [ADDR_W-1:0]        aer_addr;
  logic                     aer_ack;
  logic                     req;
  logic                     grant;
  logic [TS_W+ADDR_W-1:0]   evt_data;

  modport master (
    input  aer_req, aer_addr, grant,
    output aer_ack, req, evt_data
  );

  modport slave (
    output aer_req, aer_addr, grant,
    input  aer_ack, req, evt_data
  );

endinterface

// File: rtl/dvs_ravens_evt_fifo.sv
// rtl/dvs_ravens_evt_fifo.sv - synchronous event FIFO with occupancy counter
//
// Purpose: buffers dvs_evt_t-shaped words between capture and drain.
// Ports: clk, rst_n (async active-low), push/push_data, pop/pop_data (head,
//        combinational read), full, empty, level (0..DEPTH).
// DEPTH must be a power of two so the pointers wrap naturally.
module dvs_ravens_evt_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  pop_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);

  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full     = (level == FULL_LVL);
  assign empty    = (level == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/dvs_ravens_aer_capture.sv
// rtl/dvs_ravens_aer_capture.sv - DVS AER handshake capture, timestamping and arbiter drain
//
// Purpose: completes the 4-phase AER handshake with the camera, tags each
// event with a free-running timestamp, buffers it and offers it to one
// arbiter req/grant pair.
// Ports: clk, rst_n (async active-low); bus (master modport: aer_req,
//        aer_addr, aer_ack, req, grant, evt_data); fifo_level (occupancy);
//        drop_cnt (saturating dropped-event count); clr_drop (sync clear).
module dvs_ravens_aer_capture #(
  parameter int ADDR_W       = dvs_ravens_pkg::AER_ADDR_W,
  parameter int TS_W         = dvs_ravens_pkg::TS_W,
  parameter int FIFO_DEPTH   = dvs_ravens_pkg::EVT_FIFO_DEPTH,
  parameter int SYNC_STAGES  = 2,
  parameter int DROP_ON_FULL = 1,
  localparam int LVL_W       = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  dvs_ravens_aer_capture_if.master bus,
  output logic [LVL_W-1:0]        fifo_level,
  output logic [7:0]              drop_cnt,
  input  logic                    clr_drop
);

  import dvs_ravens_pkg::*;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   req_s;
  logic [TS_W-1:0]        ts_q;
  aer_cap_state_t         state_q;
  aer_cap_state_t         state_d;
  logic                   ack_q;
  logic                   ack_d;
  logic                   push;
  logic                   drop;
  logic                   pop;
  logic                   fifo_full;
  logic                   fifo_empty;

  // aer_req is asynchronous; aer_addr is not synchronized because the camera
  // holds it stable until our ack, so it is settled by the time req_s rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], bus.aer_req};
  end
  assign req_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ts_q <= '0;
    else        ts_q <= ts_q + 1'b1;
  end

  // fifo_full reflects the registered level, so a pop in the same cycle
  // never opens room for a push: no pass-through when full.
  always_comb begin
    state_d = state_q;
    ack_d   = ack_q;
    push    = 1'b0;
    drop    = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_s) begin
          if (!fifo_full) begin
            push    = 1'b1;
            ack_d   = 1'b1;
            state_d = ACK_HI;
          end else if (DROP_ON_FULL != 0) begin
            drop    = 1'b1;
            ack_d   = 1'b1;
            state_d = ACK_HI;
          end else begin
            state_d = STALL;
          end
        end
      end
      STALL: begin
        if (!fifo_full) begin
          push    = 1'b1;
          ack_d   = 1'b1;
          state_d = ACK_HI;
        end
      end
      ACK_HI: begin
        if (!req_s) begin
          ack_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        ack_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
    end
  end
  assign bus.aer_ack = ack_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         drop_cnt <= '0;
    else if (clr_drop)                  drop_cnt <= '0;
    else if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
  end

  assign bus.req = !fifo_empty;
  assign pop     = bus.req && bus.grant;

  dvs_ravens_evt_fifo #(
    .W     (TS_W + ADDR_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data ({ts_q, bus.aer_addr}),
    .pop       (pop),
    .pop_data  (bus.evt_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

endmodule

// File: tb/tb_dvs_ravens_aer_capture.sv
// tb/tb_dvs_ravens_aer_capture.sv - scoreboard bench for dvs_ravens_aer_capture
module tb_dvs_ravens_aer_capture;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // index 0: drop-on-full, 1: stall-on-full, 2: 4-bit timestamp
  logic        req_in   [3];
  logic [15:0] addr_in  [3];
  logic        grant_in [3];
  logic        clr      [3];
  logic        ack_out  [3];
  logic        req_out  [3];
  logic [31:0] data_out [3];
  logic [3:0]  lvl      [3];
  logic [7:0]  dcnt     [3];

  logic [15:0] ts_model;
  logic [31:0] sb [$];
  int vectors = 0;
  int miscompares = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ts_model <= 16'd0;
    else        ts_model <= ts_model + 16'd1;
  end

  dvs_ravens_aer_capture_if #(.ADDR_W(16), .TS_W(16)) if0 ();
  dvs_ravens_aer_capture_if #(.ADDR_W(16), .TS_W(16)) if1 ();
  dvs_ravens_aer_capture_if #(.ADDR_W(16), .TS_W(4))  if2 ();

  dvs_ravens_aer_capture #(.ADDR_W(16), .TS_W(16), .FIFO_DEPTH(8), .SYNC_STAGES(2), .DROP_ON_FULL(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(if0.master), .fifo_level(lvl[0]), .drop_cnt(dcnt[0]), .clr_drop(clr[0]));
  dvs_ravens_aer_capture #(.ADDR_W(16), .TS_W(16), .FIFO_DEPTH(8), .SYNC_STAGES(2), .DROP_ON_FULL(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1.master), .fifo_level(lvl[1]), .drop_cnt(dcnt[1]), .clr_drop(clr[1]));
  dvs_ravens_aer_capture #(.ADDR_W(16), .TS_W(4), .FIFO_DEPTH(8), .SYNC_STAGES(2), .DROP_ON_FULL(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(if2.master), .fifo_level(lvl[2]), .drop_cnt(dcnt[2]), .clr_drop(clr[2]));

  assign if0.aer_req = req_in[0];  assign if0.aer_addr = addr_in[0];  assign if0.grant = grant_in[0];
  assign if1.aer_req = req_in[1];  assign if1.aer_addr = addr_in[1];  assign if1.grant = grant_in[1];
  assign if2.aer_req = req_in[2];  assign if2.aer_addr = addr_in[2];  assign if2.grant = grant_in[2];
  assign ack_out[0] = if0.aer_ack; assign req_out[0] = if0.req; assign data_out[0] = if0.evt_data;
  assign ack_out[1] = if1.aer_ack; assign req_out[1] = if1.req; assign data_out[1] = if1.evt_data;
  assign ack_out[2] = if2.aer_ack; assign req_out[2] = if2.req; assign data_out[2] = {12'h000, if2.evt_data};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_ack(input int sel, input logic val);
    for (int i = 0; i < 30; i++) begin
      if (ack_out[sel] === val) break;
      tick();
    end
  endtask

  function automatic logic [31:0] exp_evt(input int sel, input logic [15:0] ts, input logic [15:0] addr);
    if (sel == 2) return {12'h000, ts[3:0], addr};
    return {ts, addr};
  endfunction

  // Full 4-phase handshake; the expected tag is the counter two edges after raise.
  task automatic handshake(input int sel, input logic [15:0] addr, input bit dropped);
    addr_in[sel] = addr;
    req_in[sel]  = 1'b1;
    if (!dropped) sb.push_back(exp_evt(sel, ts_model + 16'd2, addr));
    wait_ack(sel, 1'b1);
    vectors++;
    if (ack_out[sel] !== 1'b1) begin miscompares++; $display("FAIL hs_ack[%0d]: got %b want 1", sel, ack_out[sel]); end
    req_in[sel] = 1'b0;
    wait_ack(sel, 1'b0);
    vectors++;
    if (ack_out[sel] !== 1'b0) begin miscompares++; $display("FAIL hs_release[%0d]: got %b want 0", sel, ack_out[sel]); end
  endtask

  // Grant held high: entries must come out back-to-back in push order.
  task automatic drain(input int sel, input int n);
    logic [31:0] exp;
    grant_in[sel] = 1'b1;
    for (int i = 0; i < n; i++) begin
      vectors++;
      if (req_out[sel] !== 1'b1) begin miscompares++; $display("FAIL drain_req[%0d] #%0d: got %b want 1", sel, i, req_out[sel]); end
      if (sb.size() > 0) exp = sb.pop_front();
      else exp = 32'hxxxx_xxxx;
      vectors++;
      if (data_out[sel] !== exp) begin miscompares++; $display("FAIL drain_data[%0d] #%0d: got %h want %h", sel, i, data_out[sel], exp); end
      tick();
    end
    grant_in[sel] = 1'b0;
    vectors++;
    if (req_out[sel] !== 1'b0 || lvl[sel] !== 4'd0) begin
      miscompares++; $display("FAIL drain_empty[%0d]: req %b level %0d want 0/0", sel, req_out[sel], lvl[sel]);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int s = 0; s < 3; s++) begin
      req_in[s] = 1'b0; addr_in[s] = 16'h0; grant_in[s] = 1'b0; clr[s] = 1'b0;
    end
    ticks(3);
    for (int s = 0; s < 3; s++) begin
      vectors++; if (ack_out[s] !== 1'b0) begin miscompares++; $display("FAIL rst_ack[%0d]: got %b want 0", s, ack_out[s]); end
      vectors++; if (req_out[s] !== 1'b0) begin miscompares++; $display("FAIL rst_req[%0d]: got %b want 0", s, req_out[s]); end
      vectors++; if (lvl[s] !== 4'd0) begin miscompares++; $display("FAIL rst_level[%0d]: got %0d want 0", s, lvl[s]); end
      vectors++; if (dcnt[s] !== 8'd0) begin miscompares++; $display("FAIL rst_drop[%0d]: got %0d want 0", s, dcnt[s]); end
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_event();
    grant_in[0] = 1'b1;
    ticks(2);
    grant_in[0] = 1'b0;
    vectors++;
    if (req_out[0] !== 1'b0 || lvl[0] !== 4'd0) begin miscompares++; $display("FAIL grant_idle: req %b level %0d want 0/0", req_out[0], lvl[0]); end
    addr_in[0] = 16'h1234;
    req_in[0]  = 1'b1;
    sb.push_back(exp_evt(0, ts_model + 16'd2, 16'h1234));
    ticks(2);
    vectors++; if (ack_out[0] !== 1'b0) begin miscompares++; $display("FAIL ack_early: got %b want 0", ack_out[0]); end
    tick();
    vectors++; if (ack_out[0] !== 1'b1) begin miscompares++; $display("FAIL ack_latency: got %b want 1", ack_out[0]); end
    vectors++; if (lvl[0] !== 4'd1) begin miscompares++; $display("FAIL single_level: got %0d want 1", lvl[0]); end
    req_in[0] = 1'b0;
    ticks(2);
    vectors++; if (ack_out[0] !== 1'b1) begin miscompares++; $display("FAIL release_early: got %b want 1", ack_out[0]); end
    tick();
    vectors++; if (ack_out[0] !== 1'b0) begin miscompares++; $display("FAIL release_latency: got %b want 0", ack_out[0]); end
    drain(0, 1);
  endtask

  task automatic test_fill_drop();
    for (int i = 0; i < 8; i++) handshake(0, 16'(i), 1'b0);
    vectors++; if (lvl[0] !== 4'd8) begin miscompares++; $display("FAIL fill_level: got %0d want 8", lvl[0]); end
    handshake(0, 16'h0099, 1'b1);
    vectors++; if (dcnt[0] !== 8'd1) begin miscompares++; $display("FAIL drop_cnt: got %0d want 1", dcnt[0]); end
    vectors++; if (lvl[0] !== 4'd8) begin miscompares++; $display("FAIL drop_level: got %0d want 8", lvl[0]); end
    drain(0, 8);
  endtask

  task automatic test_drop_saturate();
    for (int i = 0; i < 8; i++) handshake(0, 16'h0A00 + 16'(i), 1'b0);
    for (int i = 0; i < 260; i++) handshake(0, 16'hDD00, 1'b1);
    vectors++; if (dcnt[0] !== 8'd255) begin miscompares++; $display("FAIL drop_saturate: got %0d want 255", dcnt[0]); end
    // clear lands on the same edge as another drop
    addr_in[0] = 16'hDD01;
    req_in[0]  = 1'b1;
    ticks(2);
    clr[0] = 1'b1;
    tick();
    clr[0] = 1'b0;
    vectors++; if (ack_out[0] !== 1'b1) begin miscompares++; $display("FAIL clr_drop_ack: got %b want 1", ack_out[0]); end
    vectors++; if (dcnt[0] !== 8'd0) begin miscompares++; $display("FAIL clr_priority: got %0d want 0", dcnt[0]); end
    req_in[0] = 1'b0;
    wait_ack(0, 1'b0);
    drain(0, 8);
  endtask

  task automatic test_simultaneous();
    logic [31:0] exp;
    for (int i = 0; i < 3; i++) handshake(0, 16'h5500 + 16'(i), 1'b0);
    vectors++; if (lvl[0] !== 4'd3) begin miscompares++; $display("FAIL simul_pre_level: got %0d want 3", lvl[0]); end
    addr_in[0] = 16'h55AA;
    req_in[0]  = 1'b1;
    sb.push_back(exp_evt(0, ts_model + 16'd2, 16'h55AA));
    ticks(2);
    exp = sb.pop_front();
    vectors++; if (data_out[0] !== exp) begin miscompares++; $display("FAIL simul_head: got %h want %h", data_out[0], exp); end
    grant_in[0] = 1'b1;
    tick();
    grant_in[0] = 1'b0;
    vectors++; if (ack_out[0] !== 1'b1) begin miscompares++; $display("FAIL simul_ack: got %b want 1", ack_out[0]); end
    vectors++; if (lvl[0] !== 4'd3) begin miscompares++; $display("FAIL simul_level: got %0d want 3", lvl[0]); end
    req_in[0] = 1'b0;
    wait_ack(0, 1'b0);
    drain(0, 3);
  endtask

  task automatic test_stall();
    logic [31:0] exp;
    for (int i = 0; i < 8; i++) handshake(1, 16'h1100 + 16'(i), 1'b0);
    addr_in[1] = 16'h11FF;
    req_in[1]  = 1'b1;
    ticks(6);
    vectors++; if (ack_out[1] !== 1'b0) begin miscompares++; $display("FAIL stall_ack: got %b want 0", ack_out[1]); end
    vectors++; if (lvl[1] !== 4'd8) begin miscompares++; $display("FAIL stall_level: got %0d want 8", lvl[1]); end
    exp = sb.pop_front();
    vectors++; if (data_out[1] !== exp) begin miscompares++; $display("FAIL stall_head: got %h want %h", data_out[1], exp); end
    grant_in[1] = 1'b1;
    tick();
    grant_in[1] = 1'b0;
    vectors++; if (ack_out[1] !== 1'b0) begin miscompares++; $display("FAIL stall_no_passthru: got %b want 0", ack_out[1]); end
    sb.push_back(exp_evt(1, ts_model, 16'h11FF));
    tick();
    vectors++; if (ack_out[1] !== 1'b1) begin miscompares++; $display("FAIL stall_release_ack: got %b want 1", ack_out[1]); end
    vectors++; if (lvl[1] !== 4'd8) begin miscompares++; $display("FAIL stall_refill: got %0d want 8", lvl[1]); end
    req_in[1] = 1'b0;
    wait_ack(1, 1'b0);
    drain(1, 8);
  endtask

  task automatic test_ts_wrap();
    for (int i = 0; i < 20; i++) begin
      if (ts_model[3:0] == 4'd13) break;
      tick();
    end
    handshake(2, 16'h7001, 1'b0);
    handshake(2, 16'h7002, 1'b0);
    vectors++; if (data_out[2][19:16] !== 4'd15) begin miscompares++; $display("FAIL ts_at_15: got %0d want 15", data_out[2][19:16]); end
    drain(2, 2);
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 8; i++) handshake(0, 16'h3300 + 16'(i), 1'b0);
    addr_in[0] = 16'hBEEF;
    req_in[0]  = 1'b1;
    wait_ack(0, 1'b1);
    vectors++; if (dcnt[0] !== 8'd1) begin miscompares++; $display("FAIL mid_pre_drop: got %0d want 1", dcnt[0]); end
    rst_n = 1'b0;
    #2;
    vectors++; if (ack_out[0] !== 1'b0) begin miscompares++; $display("FAIL mid_rst_ack: got %b want 0", ack_out[0]); end
    vectors++; if (lvl[0] !== 4'd0) begin miscompares++; $display("FAIL mid_rst_level: got %0d want 0", lvl[0]); end
    vectors++; if (dcnt[0] !== 8'd0) begin miscompares++; $display("FAIL mid_rst_drop: got %0d want 0", dcnt[0]); end
    vectors++; if (req_out[0] !== 1'b0) begin miscompares++; $display("FAIL mid_rst_req: got %b want 0", req_out[0]); end
    sb.delete();
    #2;
    rst_n = 1'b1;
    sb.push_back(exp_evt(0, ts_model + 16'd2, 16'hBEEF));
    ticks(2);
    vectors++; if (ack_out[0] !== 1'b0) begin miscompares++; $display("FAIL recapture_early: got %b want 0", ack_out[0]); end
    tick();
    vectors++; if (ack_out[0] !== 1'b1) begin miscompares++; $display("FAIL recapture_ack: got %b want 1", ack_out[0]); end
    req_in[0] = 1'b0;
    wait_ack(0, 1'b0);
    drain(0, 1);
  endtask

  initial begin
    test_reset();
    test_single_event();
    test_fill_drop();
    test_drop_saturate();
    test_simultaneous();
    test_stall();
    test_ts_wrap();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout want finish");
    $fatal(1);
  end

endmodule
